// File: rtl/uart_frame_pkg.sv
// Shared constants, state encoding and checksum helper for the UART command-frame parser.
package uart_frame_pkg;

  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hAA;

  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;
  localparam logic [1:0] ERR_TO   = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR2 = 3'd1,
    CMD  = 3'd2,
    LEN  = 3'd3,
    DATA = 3'd4,
    CSUM = 3'd5
  } state_e;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte gap timer: reloads on every received byte, counts down while a frame is open,
// and flags expiry when the terminal count is reached.
module uart_frame_timeout #(
  parameter int TIMEOUT_CYC = 60_000,
  parameter int TO_WIDTH    = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [TO_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)                     cnt_d = TO_WIDTH'(TIMEOUT_CYC - 1);
    else if (i_en && cnt_q != '0)  cnt_d = cnt_q - TO_WIDTH'(1);
  end

  // Reaching zero means TIMEOUT_CYC-1 idle clocks have elapsed since the last byte.
  assign o_expire = i_en && (cnt_q == '0);

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles 55 AA | CMD | LEN | PAYLOAD | CSUM frames from the UART byte stream.
// Define UART_FRAME_TIMEOUT_EN to add the inter-byte timeout (error code 11).
//
// state | meaning
// IDLE  | hunting for first header byte 0x55
// HDR2  | waiting for 0xAA (repeated 0x55 tolerated)
// CMD   | next byte is the command
// LEN   | next byte is the payload length
// DATA  | receiving payload bytes, written out as they arrive
// CSUM  | next byte is the checksum over CMD, LEN and payload
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter  int CLK_FREQUENCY = 60_000_000,
  parameter  int MAX_LEN       = 64,
  parameter  int TIMEOUT_CYC   = CLK_FREQUENCY / 1000,
  localparam int ADDR_WIDTH    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int TO_WIDTH      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx_vld,
  input  logic [7:0]            i_rx_data,
  output logic                  o_pl_wr,
  output logic [ADDR_WIDTH-1:0] o_pl_addr,
  output logic [7:0]            o_pl_data,
  output logic [7:0]            o_cmd,
  output logic [7:0]            o_len,
  output logic                  o_frame_vld,
  output logic                  o_frame_err,
  output logic [1:0]            o_err_code
);

  state_e                state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            csum_q, csum_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  pl_wr_q, pl_wr_d;
  logic [ADDR_WIDTH-1:0] pl_addr_q, pl_addr_d;
  logic [7:0]            pl_data_q, pl_data_d;
  logic [7:0]            cmd_out_q, cmd_out_d;
  logic [7:0]            len_out_q, len_out_d;
  logic                  frame_vld_q, frame_vld_d;
  logic                  frame_err_q, frame_err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  to_expire;
  logic                  len_too_big;
  logic                  last_data;

  assign len_too_big = i_rx_data > 8'(MAX_LEN);
  assign last_data   = 8'(idx_q) == (len_q - 8'd1);

`ifdef UART_FRAME_TIMEOUT_EN
  uart_frame_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_WIDTH    (TO_WIDTH)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (i_rx_vld),
    .i_en     (state_q != IDLE),
    .o_expire (to_expire)
  );
`else
  logic unused_to_cfg;
  assign unused_to_cfg = TIMEOUT_CYC[0] ^ TO_WIDTH[0];
  assign to_expire     = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      len_q       <= '0;
      csum_q      <= '0;
      idx_q       <= '0;
      pl_wr_q     <= 1'b0;
      pl_addr_q   <= '0;
      pl_data_q   <= '0;
      cmd_out_q   <= '0;
      len_out_q   <= '0;
      frame_vld_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      idx_q       <= idx_d;
      pl_wr_q     <= pl_wr_d;
      pl_addr_q   <= pl_addr_d;
      pl_data_q   <= pl_data_d;
      cmd_out_q   <= cmd_out_d;
      len_out_q   <= len_out_d;
      frame_vld_q <= frame_vld_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // A byte arriving on the expiry clock takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    if (i_rx_vld) begin
      unique case (state_q)
        IDLE:    if (i_rx_data == HDR0) state_d = HDR2;
        HDR2: begin
          if (i_rx_data == HDR1)      state_d = CMD;
          else if (i_rx_data != HDR0) state_d = IDLE;
        end
        CMD:     state_d = LEN;
        LEN: begin
          if (len_too_big)            state_d = IDLE;
          else if (i_rx_data == 8'd0) state_d = CSUM;
          else                        state_d = DATA;
        end
        DATA:    if (last_data) state_d = CSUM;
        CSUM:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (to_expire) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    cmd_d       = cmd_q;
    len_d       = len_q;
    csum_d      = csum_q;
    idx_d       = idx_q;
    pl_wr_d     = 1'b0;
    pl_addr_d   = pl_addr_q;
    pl_data_d   = pl_data_q;
    cmd_out_d   = cmd_out_q;
    len_out_d   = len_out_q;
    frame_vld_d = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    if (i_rx_vld) begin
      case (state_q)
        CMD: begin
          cmd_d  = i_rx_data;
          csum_d = i_rx_data;
        end
        LEN: begin
          len_d  = i_rx_data;
          csum_d = csum_add(csum_q, i_rx_data);
          idx_d  = '0;
          if (len_too_big) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
          end
        end
        DATA: begin
          pl_wr_d   = 1'b1;
          pl_addr_d = idx_q;
          pl_data_d = i_rx_data;
          csum_d    = csum_add(csum_q, i_rx_data);
          idx_d     = idx_q + ADDR_WIDTH'(1);
        end
        CSUM: begin
          if (i_rx_data == csum_q) begin
            frame_vld_d = 1'b1;
            cmd_out_d   = cmd_q;
            len_out_d   = len_q;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
          end
        end
        default: ;
      endcase
    end else if (to_expire) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TO;
    end
  end

  assign o_pl_wr     = pl_wr_q;
  assign o_pl_addr   = pl_addr_q;
  assign o_pl_data   = pl_data_q;
  assign o_cmd       = cmd_out_q;
  assign o_len       = len_out_q;
  assign o_frame_vld = frame_vld_q;
  assign o_frame_err = frame_err_q;
  assign o_err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed frames plus randomly built frames whose expected
// writes and result come from how each frame was constructed.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 64;
  localparam int AW      = $clog2(MAX_LEN);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_vld = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          pl_wr;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;
  logic [7:0]    cmd;
  logic [7:0]    len;
  logic          frame_vld;
  logic          frame_err;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  uart_frame_parser #(
    .CLK_FREQUENCY (100_000),
    .MAX_LEN       (MAX_LEN)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx_vld    (rx_vld),
    .i_rx_data   (rx_data),
    .o_pl_wr     (pl_wr),
    .o_pl_addr   (pl_addr),
    .o_pl_data   (pl_data),
    .o_cmd       (cmd),
    .o_len       (len),
    .o_frame_vld (frame_vld),
    .o_frame_err (frame_err),
    .o_err_code  (err_code)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_vld = 0;
  int n_err = 0;
  int got_addr[$];
  int got_data[$];

  // expected values of the held outputs
  int last_cmd = 0;
  int last_len = 0;
  int last_addr = 0;
  int last_data = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pl_wr) begin
      got_addr.push_back(int'(pl_addr));
      got_data.push_back(int'(pl_data));
    end
    if (frame_vld) n_vld++;
    if (frame_err) n_err++;
    if (frame_vld || frame_err) chk("vld_err_exclusive", 32'(frame_vld & frame_err), 32'(0));
  end

  task automatic send_byte(input logic [7:0] b);
    rx_vld  = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_vld  = 1'b0;
  endtask

  // kind: 1 = frame accepted, 2 = frame aborted with ecode
  task automatic run_frame(input string tag, input logic [7:0] bytes[$], input logic [7:0] pl[$],
                           input int kind, input logic [7:0] ecmd, input logic [7:0] elen,
                           input logic [1:0] ecode, input int gap_max);
    got_addr.delete();
    got_data.delete();
    n_vld = 0;
    n_err = 0;
    foreach (bytes[i]) begin
      if (i > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      send_byte(bytes[i]);
    end
    chk({tag, "_vld_timing"}, 32'(frame_vld), 32'(kind == 1));
    chk({tag, "_err_timing"}, 32'(frame_err), 32'(kind == 2));
    if (kind == 2) chk({tag, "_err_code"}, 32'(err_code), 32'(ecode));
    repeat (2) @(negedge clk);
    chk({tag, "_vld_count"}, n_vld, 32'(kind == 1));
    chk({tag, "_err_count"}, n_err, 32'(kind == 2));
    chk({tag, "_wr_count"}, got_data.size(), pl.size());
    foreach (pl[i]) begin
      if (i < got_data.size()) begin
        chk({tag, "_wr_addr"}, got_addr[i], i);
        chk({tag, "_wr_data"}, got_data[i], 32'(pl[i]));
      end
    end
    if (pl.size() > 0) begin
      last_addr = pl.size() - 1;
      last_data = int'(pl[pl.size() - 1]);
    end
    if (kind == 1) begin
      last_cmd = int'(ecmd);
      last_len = int'(elen);
    end
    chk({tag, "_cmd_out"}, 32'(cmd), last_cmd);
    chk({tag, "_len_out"}, 32'(len), last_len);
    chk({tag, "_pl_addr_hold"}, 32'(pl_addr), last_addr);
    chk({tag, "_pl_data_hold"}, 32'(pl_data), last_data);
  endtask

  // Builds CMD LEN PAYLOAD CSUM (payload and checksum omitted when LEN is too large).
  task automatic mk_frame(input logic [7:0] c, input int l, input bit good,
                          output logic [7:0] body[$], output logic [7:0] pl[$]);
    int sum;
    body.delete();
    pl.delete();
    body.push_back(c);
    body.push_back(8'(l));
    sum = int'(c) + l;
    if (l <= MAX_LEN) begin
      for (int i = 0; i < l; i++) begin
        pl.push_back(8'($urandom));
        sum += int'(pl[i]);
        body.push_back(pl[i]);
      end
      sum = sum % 256;
      if (!good) sum = (sum + int'($urandom_range(255, 1))) % 256;
      body.push_back(8'(sum));
    end
  endtask

  logic [7:0] qb[$];
  logic [7:0] qp[$];
  logic [7:0] body[$];

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pl_wr", 32'(pl_wr), 32'(0));
    chk("rst_frame_vld", 32'(frame_vld), 32'(0));
    chk("rst_frame_err", 32'(frame_err), 32'(0));
    chk("rst_cmd", 32'(cmd), 32'(0));
    chk("rst_len", 32'(len), 32'(0));
    chk("rst_pl_addr", 32'(pl_addr), 32'(0));
    chk("rst_err_code", 32'(err_code), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    qb = '{8'h55, 8'hAA, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h64};
    qp = '{8'h10, 8'h20, 8'h30};
    run_frame("good", qb, qp, 1, 8'h01, 8'h03, 2'b00, 2);

    qb = '{8'h55, 8'hAA, 8'h07, 8'h00, 8'h07};
    qp.delete();
    run_frame("zero_len", qb, qp, 1, 8'h07, 8'h00, 2'b00, 2);

    qb = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'hAA, 8'hBB, 8'h00};
    qp = '{8'hAA, 8'hBB};
    run_frame("bad_csum", qb, qp, 2, 8'h00, 8'h00, 2'b10, 2);

    qb = '{8'h55, 8'hAA, 8'h01, 8'h41};
    qp.delete();
    run_frame("len_ovf", qb, qp, 2, 8'h00, 8'h00, 2'b01, 2);

    qb = '{8'h55, 8'hAA, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h64};
    qp = '{8'h10, 8'h20, 8'h30};
    run_frame("after_ovf", qb, qp, 1, 8'h01, 8'h03, 2'b00, 1);

    qb = '{8'h00, 8'h55, 8'h55, 8'hAA, 8'h02, 8'h01, 8'h99, 8'h9C};
    qp = '{8'h99};
    run_frame("resync", qb, qp, 1, 8'h02, 8'h01, 2'b00, 2);

    mk_frame(8'h3C, MAX_LEN, 1'b1, body, qp);
    qb = '{8'h55, 8'hAA};
    foreach (body[i]) qb.push_back(body[i]);
    run_frame("len_max", qb, qp, 1, 8'h3C, 8'(MAX_LEN), 2'b00, 0);

    // reset in the middle of the payload
    qb = '{8'h55, 8'hAA, 8'h05, 8'h03, 8'h11, 8'h22};
    foreach (qb[i]) send_byte(qb[i]);
    n_vld = 0;
    n_err = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_pl_wr", 32'(pl_wr), 32'(0));
    chk("midrst_cmd", 32'(cmd), 32'(0));
    chk("midrst_len", 32'(len), 32'(0));
    chk("midrst_pl_addr", 32'(pl_addr), 32'(0));
    chk("midrst_pl_data", 32'(pl_data), 32'(0));
    chk("midrst_err_code", 32'(err_code), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_no_pulse", n_vld + n_err, 0);
    last_cmd = 0;
    last_len = 0;
    last_addr = 0;
    last_data = 0;
    qb = '{8'h55, 8'hAA, 8'h09, 8'h01, 8'h5A, 8'h64};
    qp = '{8'h5A};
    run_frame("after_rst", qb, qp, 1, 8'h09, 8'h01, 2'b00, 1);

    for (int f = 0; f < 40; f++) begin
      logic [7:0] c;
      logic [7:0] b;
      int l;
      int r;
      bit good;
      qb.delete();
      repeat ($urandom_range(2, 0)) begin
        b = 8'($urandom);
        if (b == 8'h55) b = 8'h00;
        qb.push_back(b);
      end
      if ($urandom_range(3, 0) == 0) begin
        b = 8'($urandom);
        if (b == 8'h55 || b == 8'hAA) b = 8'h12;
        qb.push_back(8'h55);
        qb.push_back(b);
      end
      if ($urandom_range(3, 0) == 0) qb.push_back(8'h55);
      qb.push_back(8'h55);
      qb.push_back(8'hAA);
      c = 8'($urandom);
      r = int'($urandom_range(7, 0));
      if (r == 0)      l = 0;
      else if (r == 1) l = int'($urandom_range(255, MAX_LEN + 1));
      else if (r == 2) l = MAX_LEN;
      else             l = int'($urandom_range(MAX_LEN, 1));
      good = ($urandom_range(3, 0) != 0);
      mk_frame(c, l, good, body, qp);
      foreach (body[i]) qb.push_back(body[i]);
      if (l > MAX_LEN)  run_frame("rnd_ovf", qb, qp, 2, c, 8'(l), 2'b01, 3);
      else if (good)    run_frame("rnd_good", qb, qp, 1, c, 8'(l), 2'b00, 3);
      else              run_frame("rnd_bad", qb, qp, 2, c, 8'(l), 2'b10, 3);
    end

`ifdef UART_FRAME_TIMEOUT_EN
    // 100-clock gap after CMD expires the frame
    n_err = 0;
    qb = '{8'h55, 8'hAA, 8'h01};
    foreach (qb[i]) send_byte(qb[i]);
    repeat (99) @(negedge clk);
    chk("to_early", n_err, 0);
    @(negedge clk);
    chk("to_err", 32'(frame_err), 32'(1));
    chk("to_code", 32'(err_code), 32'(3));
    repeat (2) @(negedge clk);
    chk("to_err_count", n_err, 1);
    qb = '{8'h55, 8'hAA, 8'h07, 8'h00, 8'h07};
    qp.delete();
    run_frame("after_to", qb, qp, 1, 8'h07, 8'h00, 2'b00, 2);

    // byte lands exactly on the expiry clock
    qb = '{8'h55, 8'hAA, 8'h01};
    foreach (qb[i]) send_byte(qb[i]);
    repeat (99) @(negedge clk);
    qb = '{8'h00, 8'h01};
    qp.delete();
    run_frame("to_tie", qb, qp, 1, 8'h01, 8'h00, 2'b00, 0);
`else
    // without the timeout a stalled frame simply resumes
    n_err = 0;
    qb = '{8'h55, 8'hAA, 8'h09, 8'h01};
    foreach (qb[i]) send_byte(qb[i]);
    repeat (300) @(negedge clk);
    chk("stall_no_err", n_err, 0);
    qb = '{8'h5A, 8'h64};
    qp = '{8'h5A};
    run_frame("stall", qb, qp, 1, 8'h09, 8'h01, 2'b00, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART byte receiver; consumes its per-byte valid pulse and data byte.
- Assembles bytes into command frames: 0x55 0xAA | CMD | LEN | PAYLOAD[LEN] | CSUM.
- Writes payload bytes out through a simple write port into an external buffer.
- Reports frame-done or frame-error to the camera control logic.

Parameters:
- CLK_FREQUENCY, 60_000_000, module clock in Hz; used only to size the timeout.
- MAX_LEN, 64, maximum payload bytes accepted (1..255).
- TIMEOUT_CYC, CLK_FREQUENCY/1000, inter-byte gap limit in clocks (default 1 ms).
- ADDR_WIDTH, $clog2(MAX_LEN), payload address width (derived, not overridden).
- TO_WIDTH, $clog2(TIMEOUT_CYC), timeout counter width (derived, not overridden).

Ports:
- i_clk  in  1  module clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rx_vld  in  1  byte-valid pulse from UART receiver (one clock per byte)
- i_rx_data  in  8  received byte, valid when i_rx_vld=1
- o_pl_wr  out  1  payload write strobe
- o_pl_addr  out  ADDR_WIDTH  payload byte index, 0-based
- o_pl_data  out  8  payload byte
- o_cmd  out  8  CMD of the last accepted frame
- o_len  out  8  LEN of the last accepted frame
- o_frame_vld  out  1  one-clock pulse: frame complete, checksum good
- o_frame_err  out  1  one-clock pulse: frame aborted
- o_err_code  out  2  abort reason, valid with o_frame_err: 01 length, 10 checksum, 11 timeout

Behaviour:
Reset and outputs:
- One clock domain: i_clk. Reset is asynchronous, active-low (i_rst_n).
- All outputs reset to 0. State resets to IDLE. Checksum, byte counter and timeout counter reset to 0.
- All outputs are registered. o_pl_wr, o_frame_vld and o_frame_err assert on the clock after the i_rx_vld that causes them.

State machine (advances only on i_rx_vld=1, except timeout):
- IDLE: byte==0x55 -> HDR2; any other byte stays in IDLE.
- HDR2: byte==0xAA -> CMD; byte==0x55 stays in HDR2; any other byte -> IDLE, with no error.
- CMD: latch byte into cmd_r; csum <= byte -> LEN.
- LEN:
  - byte > MAX_LEN -> IDLE with o_frame_err=1, code 01.
  - byte == 0 -> CSUM.
  - otherwise -> DATA.
  - In all three cases: len_r <= byte; csum <= csum + byte; idx <= 0.
- DATA: o_pl_wr=1, o_pl_addr=idx, o_pl_data=byte; csum += byte; idx++. When idx == len_r-1 -> CSUM.
- CSUM:
  - byte == csum[7:0]: o_frame_vld=1; o_cmd <= cmd_r; o_len <= len_r.
  - mismatch: o_frame_err=1, code 10.
  - Either way -> IDLE.

Arithmetic and output holding:
- csum is an 8-bit sum modulo 256 of CMD, LEN and all payload bytes. Headers are excluded.
- o_cmd and o_len change only on o_frame_vld and hold between frames.
- o_pl_addr and o_pl_data hold their last values when o_pl_wr=0.

Error and timeout rules:
- o_frame_vld and o_frame_err are never asserted in the same clock.
- Payload bytes already written for an aborted frame are not retracted. Downstream ignores the buffer until o_frame_vld.
- Timeout (feature enabled):
  - The counter runs in every state except IDLE and clears on each i_rx_vld.
  - At TIMEOUT_CYC-1: -> IDLE with o_frame_err=1, code 11.
  - If i_rx_vld coincides with expiry, the byte wins: it is processed and the counter clears.

Reset mid-frame:
- Returns immediately to IDLE; no error pulse is issued.

Optional Feature:
- Macro: UART_FRAME_TIMEOUT_EN.
- Defined: the inter-byte timeout counter and error code 11 exist as described above.
- Undefined:
  - No timeout counter; a stalled frame waits indefinitely.
  - Code 11 is never produced.
  - TIMEOUT_CYC and TO_WIDTH are unused.

Decomposition:
- Shared package uart_frame_pkg holds:
  - header constants HDR0=8'h55 and HDR1=8'hAA;
  - state encoding IDLE/HDR2/CMD/LEN/DATA/CSUM (3 bits);
  - error code constants ERR_LEN=2'b01, ERR_CSUM=2'b10, ERR_TO=2'b11.
- Sub-module uart_frame_timeout: a gap counter with clear/enable inputs and an expiry pulse output, instantiated only under UART_FRAME_TIMEOUT_EN.
- The FSM stays in the top module.

Test Plan:
- Good frame: bytes 55 AA 01 03 10 20 30 64 -> o_pl_wr x3 at addr 0/1/2 with data 10/20/30; o_frame_vld=1 once; o_cmd=01; o_len=03; o_frame_err never asserted.
- Zero-length frame: 55 AA 07 00 07 -> no o_pl_wr; o_frame_vld=1; o_cmd=07; o_len=00.
- Bad checksum: 55 AA 01 02 AA BB 00 -> two writes; o_frame_err=1 with o_err_code=10; o_cmd/o_len keep their previous values.
- Length overflow (MAX_LEN=64): 55 AA 01 41 -> o_frame_err=1, code 01, one clock after the 0x41 byte; a following good frame is accepted.
- Resync and noise: 00 55 55 AA 02 01 99 9C -> the repeated 0x55 is tolerated; o_frame_vld=1; payload 99 written at addr 0.
- Timeout (macro defined, TIMEOUT_CYC=100): 55 AA 01, then idle for 100 clocks -> o_frame_err=1, code 11; a byte arriving exactly at expiry is processed with no error; reset asserted mid-DATA returns to IDLE with no pulse.
